// File: rtl/mux_pkg.sv
// Shared constants, state encoding and a constant clog2 helper for the scanning mux.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wraps at terminal count; clear wins over enable.
module dwell_timer
  import mux_pkg::*;
#(
  parameter int DWELL = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = clog2(DWELL) + 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count_q, count_d;

  assign tc = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tc ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mux_scan_reg.sv
// Registered CH-input, N-bit selector with manual (switch) and round-robin scan modes.
// m and chan always update together so the display never shows a channel mismatch.
module mux_scan_reg
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int CH    = 4,
  parameter  int DWELL = 50000000,
  localparam int SEL_W = (clog2(CH) > 1) ? clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH*N-1:0]   x_bus,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  input  logic              hold,
  output logic [N-1:0]      m,
  output logic [SEL_W-1:0]  chan,
  output logic              tick
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [SEL_W-1:0] sel_clamp;
  logic [N-1:0]     m_q, m_d;
  logic             tick_q;
  logic             clear, enable, advance, tc;

  dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .enable (enable),
    .tc     (tc)
  );

  always_comb begin
    state_d   = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
    sel_clamp = (int'(sel) >= CH) ? LAST_CH : sel;
    clear     = (state_d != state_q);
    // The counter only runs once SCAN is established; the entry edge just clears it.
    enable    = (state_q == ST_SCAN) && (state_d == ST_SCAN) && !hold;
    advance   = tc && enable;
    chan_d    = chan_q;
    if (state_d == ST_MANUAL) begin
      chan_d = sel_clamp;
    end else if (advance) begin
      chan_d = (chan_q == LAST_CH) ? '0 : chan_q + SEL_W'(1);
    end
    m_d = x_bus[int'(chan_d)*N +: N];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_MANUAL;
      chan_q  <= '0;
      m_q     <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      m_q     <= m_d;
      tick_q  <= advance;
    end
  end

  assign m    = m_q;
  assign chan = chan_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: directed vector table, hand-written corner sequences, random run vs model.
module tb_mux_scan_reg;

  localparam int N = 4;
  localparam int DWELL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] x_bus = 16'h0;
  logic [1:0]  sel = 2'd0;
  logic        mode = 1'b0;
  logic        hold = 1'b0;

  logic [3:0]  m4, m3;
  logic [1:0]  chan4, chan3;
  logic        tick4, tick3;

  always #5 clk = ~clk;

  mux_scan_reg #(.N(N), .CH(4), .DWELL(DWELL)) dut4 (
    .clk(clk), .reset(reset), .x_bus(x_bus), .sel(sel), .mode(mode), .hold(hold),
    .m(m4), .chan(chan4), .tick(tick4)
  );

  mux_scan_reg #(.N(N), .CH(3), .DWELL(DWELL)) dut3 (
    .clk(clk), .reset(reset), .x_bus(x_bus[11:0]), .sel(sel), .mode(mode), .hold(hold),
    .m(m3), .chan(chan3), .tick(tick3)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a scan position (channel, clocks spent on it) per instance.
  int  ms_scan [2];
  int  ms_chan [2];
  int  ms_cnt  [2];
  int  exp_m   [2];
  int  exp_c   [2];
  int  exp_t   [2];

  function automatic void model_step(input int k, input int ch, input bit rst, input int s,
                                     input bit md, input bit hd, input logic [15:0] x);
    exp_t[k] = 0;
    if (rst) begin
      ms_scan[k] = 0; ms_chan[k] = 0; ms_cnt[k] = 0;
    end else if (!md) begin
      ms_scan[k] = 0; ms_cnt[k] = 0;
      ms_chan[k] = (s >= ch) ? ch - 1 : s;
    end else if (ms_scan[k] == 0) begin
      ms_scan[k] = 1; ms_cnt[k] = 0;
    end else if (!hd) begin
      if (ms_cnt[k] == DWELL - 1) begin
        ms_cnt[k] = 0;
        ms_chan[k] = (ms_chan[k] + 1) % ch;
        exp_t[k] = 1;
      end else begin
        ms_cnt[k] = ms_cnt[k] + 1;
      end
    end
    exp_c[k] = ms_chan[k];
    exp_m[k] = rst ? 0 : int'((x >> (4 * ms_chan[k])) & 16'hF);
  endfunction

  task automatic step(input bit r, input int s, input bit md, input bit hd, input logic [15:0] x);
    reset = r; sel = 2'(s); mode = md; hold = hd; x_bus = x;
    @(posedge clk);
    #1;
    model_step(0, 4, r, s, md, hd, x);
    model_step(1, 3, r, s, md, hd, x);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".m4"},    int'(m4),    exp_m[0]);
    chk({tag, ".chan4"}, int'(chan4), exp_c[0]);
    chk({tag, ".tick4"}, int'(tick4), exp_t[0]);
    chk({tag, ".m3"},    int'(m3),    exp_m[1]);
    chk({tag, ".chan3"}, int'(chan3), exp_c[1]);
    chk({tag, ".tick3"}, int'(tick3), exp_t[1]);
  endtask

  typedef struct {
    bit          rst;
    int          s;
    bit          md;
    bit          hd;
    logic [15:0] x;
    int          em;
    int          ec;
    int          et;
  } vec_t;

  vec_t vt [40];

  function automatic vec_t mk(input bit r, input int s, input bit md, input bit hd,
                              input logic [15:0] x, input int em, input int ec, input int et);
    vec_t v;
    v.rst = r; v.s = s; v.md = md; v.hd = hd; v.x = x; v.em = em; v.ec = ec; v.et = et;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected values after each edge, CH=4, DWELL=3.
    vt[0]  = mk(1, 2, 0, 0, 16'hDCBA, 0,     0, 0);
    vt[1]  = mk(1, 2, 0, 0, 16'hDCBA, 0,     0, 0);
    vt[2]  = mk(0, 2, 0, 0, 16'hDCBA, 4'hC,  2, 0);
    vt[3]  = mk(0, 1, 0, 0, 16'h4321, 2,     1, 0);
    vt[4]  = mk(0, 3, 0, 0, 16'h4321, 4,     3, 0);
    vt[5]  = mk(0, 0, 0, 0, 16'h4321, 1,     0, 0);
    vt[6]  = mk(0, 0, 1, 0, 16'h4321, 1,     0, 0);
    vt[7]  = mk(0, 0, 1, 0, 16'h4321, 1,     0, 0);
    vt[8]  = mk(0, 0, 1, 0, 16'h4321, 1,     0, 0);
    vt[9]  = mk(0, 0, 1, 0, 16'h4321, 2,     1, 1);
    vt[10] = mk(0, 0, 1, 0, 16'h4321, 2,     1, 0);
    vt[11] = mk(0, 0, 1, 0, 16'h4321, 2,     1, 0);
    vt[12] = mk(0, 0, 1, 0, 16'h4321, 3,     2, 1);
    vt[13] = mk(0, 0, 1, 0, 16'h4321, 3,     2, 0);
    vt[14] = mk(0, 0, 1, 0, 16'h4321, 3,     2, 0);
    vt[15] = mk(0, 0, 1, 0, 16'h4321, 4,     3, 1);
    vt[16] = mk(0, 0, 1, 0, 16'h4321, 4,     3, 0);
    vt[17] = mk(0, 0, 1, 0, 16'h4321, 4,     3, 0);
    vt[18] = mk(0, 0, 1, 0, 16'h4321, 1,     0, 1);
    vt[19] = mk(0, 0, 1, 0, 16'h4321, 1,     0, 0);
    vt[20] = mk(0, 0, 1, 0, 16'h4321, 1,     0, 0);
    vt[21] = mk(0, 0, 1, 1, 16'h4321, 1,     0, 0);
    vt[22] = mk(0, 0, 1, 1, 16'h4321, 1,     0, 0);
    vt[23] = mk(0, 0, 1, 1, 16'h4329, 9,     0, 0);
    vt[24] = mk(0, 0, 1, 1, 16'h4329, 9,     0, 0);
    vt[25] = mk(0, 0, 1, 1, 16'h4329, 9,     0, 0);
    vt[26] = mk(0, 0, 1, 0, 16'h4329, 2,     1, 1);
    vt[27] = mk(0, 0, 1, 0, 16'h4321, 2,     1, 0);
    vt[28] = mk(0, 3, 0, 0, 16'h4321, 4,     3, 0);
    vt[29] = mk(0, 3, 1, 0, 16'h4321, 4,     3, 0);
    vt[30] = mk(0, 3, 1, 0, 16'h4321, 4,     3, 0);
    vt[31] = mk(0, 3, 1, 0, 16'h4321, 4,     3, 0);
    vt[32] = mk(0, 3, 1, 0, 16'h4321, 1,     0, 1);
    vt[33] = mk(0, 3, 1, 0, 16'h4321, 1,     0, 0);
    vt[34] = mk(0, 3, 1, 1, 16'h4321, 1,     0, 0);
    vt[35] = mk(1, 2, 1, 1, 16'h4321, 0,     0, 0);
    vt[36] = mk(0, 2, 1, 0, 16'h4321, 1,     0, 0);
    vt[37] = mk(0, 2, 1, 0, 16'h4321, 1,     0, 0);
    vt[38] = mk(0, 2, 1, 0, 16'h4321, 1,     0, 0);
    vt[39] = mk(0, 2, 1, 0, 16'h4321, 2,     1, 1);

    for (int i = 0; i < 40; i++) begin
      step(vt[i].rst, vt[i].s, vt[i].md, vt[i].hd, vt[i].x);
      chk($sformatf("vec%0d.m", i),    int'(m4),    vt[i].em);
      chk($sformatf("vec%0d.chan", i), int'(chan4), vt[i].ec);
      chk($sformatf("vec%0d.tick", i), int'(tick4), vt[i].et);
      if (i == 4) begin
        chk("clamp3.chan", int'(chan3), 2);
        chk("clamp3.m",    int'(m3),    3);
      end
    end

    // Reset pulse that starts and ends between edges must be ignored.
    step(0, 1, 0, 0, 16'h4321);
    chk("glitch_pre.m", int'(m4), 2);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    step(0, 1, 0, 0, 16'h4321);
    chk("glitch.m",    int'(m4),    2);
    chk("glitch.chan", int'(chan4), 1);
    chk_model("glitch");

    // Randomised run against the reference model.
    step(1, 0, 0, 0, 16'h0);
    chk_model("rnd_rst");
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2), int'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0), 16'($urandom));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
